mode_run_controller: RTL

MODE_RUN_CONTROLLER -- requirements
Module: mode_run_controller

---
 rtl/jpegls_pkg.sv | 31 +++
 rtl/mode_run_controller_if.sv | 43 ++++
 rtl/gradient_flat_check.sv | 39 +++
 rtl/mode_run_controller.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/jpegls_pkg.sv
// Shared definitions for the JPEG-LS run-mode controller: mode codes, FSM
// states, output field widths and the run-length order table J.
package jpegls_pkg;

  localparam int REM_LEN_W     = 4;
  localparam int RUN_INDEX_W   = 5;
  localparam int RUN_INDEX_MAX = 31;

  localparam logic [1:0] MODE_REGULAR = 2'd0;
  localparam logic [1:0] MODE_RUN     = 2'd1;
  localparam logic [1:0] MODE_RUN_INT = 2'd2;
  localparam logic [1:0] MODE_EOL_INT = 2'd3;

  typedef enum logic {
    ST_REGULAR = 1'b0,
    ST_RUN     = 1'b1
  } run_state_e;

  // log2 of the run segment length coded by a single '1' at each RUNindex
  localparam logic [REM_LEN_W-1:0] J_TABLE [0:31] = '{
    4'd0, 4'd0, 4'd0, 4'd0, 4'd1, 4'd1, 4'd1, 4'd1,
    4'd2, 4'd2, 4'd2, 4'd2, 4'd3, 4'd3, 4'd3, 4'd3,
    4'd4, 4'd4, 4'd5, 4'd5, 4'd6, 4'd6, 4'd7, 4'd7,
    4'd8, 4'd9, 4'd10, 4'd11, 4'd12, 4'd13, 4'd14, 4'd15
  };

  function automatic logic [REM_LEN_W-1:0] j_of(input logic [RUN_INDEX_W-1:0] idx);
    return J_TABLE[idx];
  endfunction

endpackage

// File: rtl/mode_run_controller_if.sv
// Sample-in / decision-out bus of the run-mode controller.
interface mode_run_controller_if #(
  parameter int pixel_length  = 8,
  parameter int mode_length   = 2,
  parameter int runcnt_length = 16
);
  import jpegls_pkg::*;

  // Both channels are strict valid/ready: a transfer happens on a rising edge
  // where valid && ready; the producer holds valid and payload stable until then.
  logic [pixel_length-1:0]  a;
  logic [pixel_length-1:0]  b;
  logic [pixel_length-1:0]  c;
  logic [pixel_length-1:0]  d;
  logic [pixel_length-1:0]  x;
  logic                     EOL;
  logic                     start_frame;
  logic                     in_valid;
  logic                     in_ready;

  logic                     out_valid;
  logic                     out_ready;
  logic [mode_length-1:0]   mode;
  logic                     run_hit;
  logic                     eol_flush;
  logic [runcnt_length-1:0] rem_value;
  logic [REM_LEN_W-1:0]     rem_len;
  logic [RUN_INDEX_W-1:0]   run_index;
  logic                     state_dbg;

  modport master (
    output a, b, c, d, x, EOL, start_frame, in_valid, out_ready,
    input  in_ready, out_valid, mode, run_hit, eol_flush, rem_value, rem_len,
           run_index, state_dbg
  );

  modport slave (
    input  a, b, c, d, x, EOL, start_frame, in_valid, out_ready,
    output in_ready, out_valid, mode, run_hit, eol_flush, rem_value, rem_len,
           run_index, state_dbg
  );

endinterface

// File: rtl/gradient_flat_check.sv
// Local-gradient flatness and run-value match tests with near-lossless tolerance.
module gradient_flat_check #(
  parameter int pixel_length = 8,
  parameter int NEAR         = 0
) (
  input  logic [pixel_length-1:0] i_a,
  input  logic [pixel_length-1:0] i_b,
  input  logic [pixel_length-1:0] i_c,
  input  logic [pixel_length-1:0] i_d,
  input  logic [pixel_length-1:0] i_x,
  output logic                    o_flat,
  output logic                    o_match
);

  localparam int W = pixel_length + 1;
  localparam logic [W-1:0] NEAR_W = W'(NEAR);

  // One extra bit keeps the signed difference of two unsigned samples exact
  function automatic logic [W-1:0] abs_diff(input logic [pixel_length-1:0] p,
                                            input logic [pixel_length-1:0] q);
    logic signed [W-1:0] diff;
    diff = $signed({1'b0, p}) - $signed({1'b0, q});
    return diff[W-1] ? W'(-diff) : W'(diff);
  endfunction

  logic [W-1:0] w_db;
  logic [W-1:0] w_bc;
  logic [W-1:0] w_ca;
  logic [W-1:0] w_xa;

  assign w_db = abs_diff(i_d, i_b);
  assign w_bc = abs_diff(i_b, i_c);
  assign w_ca = abs_diff(i_c, i_a);
  assign w_xa = abs_diff(i_x, i_a);

  assign o_flat  = (w_db <= NEAR_W) && (w_bc <= NEAR_W) && (w_ca <= NEAR_W);
  assign o_match = (w_xa <= NEAR_W);

endmodule

// File: rtl/mode_run_controller.sv
// JPEG-LS mode decision and run-length bookkeeping, one sample per handshake,
// with a single registered output record.
module mode_run_controller
  import jpegls_pkg::*;
#(
  parameter int pixel_length  = 8,
  parameter int NEAR          = 0,
  parameter int mode_length   = 2,
  parameter int runcnt_length = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  mode_run_controller_if.slave  bus
);

  localparam int CW = runcnt_length + 1;

  run_state_e               r_state;
  logic [RUN_INDEX_W-1:0]   r_idx;
  logic [runcnt_length-1:0] r_runcnt;
  logic                     r_out_valid;
  logic [mode_length-1:0]   r_mode;
  logic                     r_run_hit;
  logic                     r_eol_flush;
  logic [runcnt_length-1:0] r_rem_value;
  logic [REM_LEN_W-1:0]     r_rem_len;
  logic [RUN_INDEX_W-1:0]   r_run_index;

  logic                     w_in_ready;
  logic                     w_accept;
  logic                     w_flat;
  logic                     w_match;

  assign w_in_ready = !r_out_valid || bus.out_ready;
  assign w_accept   = bus.in_valid && w_in_ready;

  gradient_flat_check #(
    .pixel_length (pixel_length),
    .NEAR         (NEAR)
  ) u_flat_check (
    .i_a     (bus.a),
    .i_b     (bus.b),
    .i_c     (bus.c),
    .i_d     (bus.d),
    .i_x     (bus.x),
    .o_flat  (w_flat),
    .o_match (w_match)
  );

  // start_frame makes the current sample see a fresh context
  run_state_e               w_cur_state;
  logic [RUN_INDEX_W-1:0]   w_cur_idx;
  logic [runcnt_length-1:0] w_cur_cnt;
  logic [REM_LEN_W-1:0]     w_j;
  logic [CW-1:0]            w_cnt_inc;
  logic [CW-1:0]            w_run_limit;
  logic                     w_hit;
  logic [runcnt_length-1:0] w_cnt_post;
  logic [RUN_INDEX_W-1:0]   w_idx_post;

  assign w_cur_state = bus.start_frame ? ST_REGULAR : r_state;
  assign w_cur_idx   = bus.start_frame ? '0 : r_idx;
  assign w_cur_cnt   = bus.start_frame ? '0 : r_runcnt;
  assign w_j         = j_of(w_cur_idx);
  assign w_cnt_inc   = {1'b0, w_cur_cnt} + CW'(1);
  assign w_run_limit = CW'(1) << w_j;
  assign w_hit       = (w_cnt_inc == w_run_limit);
  assign w_cnt_post  = w_hit ? '0 : w_cnt_inc[runcnt_length-1:0];
  assign w_idx_post  = (w_hit && (w_cur_idx != RUN_INDEX_W'(RUN_INDEX_MAX)))
                       ? w_cur_idx + RUN_INDEX_W'(1) : w_cur_idx;

  run_state_e               w_nx_state;
  logic [RUN_INDEX_W-1:0]   w_nx_idx;
  logic [runcnt_length-1:0] w_nx_cnt;
  logic [1:0]               w_nx_mode;
  logic                     w_nx_hit;
  logic                     w_nx_flush;
  logic [runcnt_length-1:0] w_nx_rem_value;
  logic [REM_LEN_W-1:0]     w_nx_rem_len;

  always_comb begin
    w_nx_state     = w_cur_state;
    w_nx_idx       = w_cur_idx;
    w_nx_cnt       = w_cur_cnt;
    w_nx_mode      = MODE_REGULAR;
    w_nx_hit       = 1'b0;
    w_nx_flush     = 1'b0;
    w_nx_rem_value = '0;
    w_nx_rem_len   = '0;
    if (w_cur_state == ST_REGULAR && !w_flat) begin
      w_nx_mode = MODE_REGULAR;
    end else if (!w_match) begin
      // Interruption wins over end-of-line and reports the partial run
      w_nx_mode      = MODE_RUN_INT;
      w_nx_rem_value = w_cur_cnt;
      w_nx_rem_len   = w_j;
      w_nx_idx       = (w_cur_idx == '0) ? '0 : w_cur_idx - RUN_INDEX_W'(1);
      w_nx_cnt       = '0;
      w_nx_state     = ST_REGULAR;
    end else if (!bus.EOL) begin
      w_nx_mode  = MODE_RUN;
      w_nx_hit   = w_hit;
      w_nx_idx   = w_idx_post;
      w_nx_cnt   = w_cnt_post;
      w_nx_state = ST_RUN;
    end else begin
      w_nx_mode  = MODE_EOL_INT;
      w_nx_hit   = w_hit;
      w_nx_flush = (w_cnt_post != '0);
      w_nx_idx   = w_idx_post;
      w_nx_cnt   = '0;
      w_nx_state = ST_REGULAR;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_REGULAR;
      r_idx       <= '0;
      r_runcnt    <= '0;
      r_out_valid <= 1'b0;
      r_mode      <= '0;
      r_run_hit   <= 1'b0;
      r_eol_flush <= 1'b0;
      r_rem_value <= '0;
      r_rem_len   <= '0;
      r_run_index <= '0;
    end else if (w_accept) begin
      r_state     <= w_nx_state;
      r_idx       <= w_nx_idx;
      r_runcnt    <= w_nx_cnt;
      r_out_valid <= 1'b1;
      r_mode      <= mode_length'(w_nx_mode);
      r_run_hit   <= w_nx_hit;
      r_eol_flush <= w_nx_flush;
      r_rem_value <= w_nx_rem_value;
      r_rem_len   <= w_nx_rem_len;
      r_run_index <= w_cur_idx;
    end else if (bus.out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.mode      = r_mode;
  assign bus.run_hit   = r_run_hit;
  assign bus.eol_flush = r_eol_flush;
  assign bus.rem_value = r_rem_value;
  assign bus.rem_len   = r_rem_len;
  assign bus.run_index = r_run_index;
  assign bus.state_dbg = r_state;

endmodule
